// File: rtl/augmented_reader.sv
`default_nettype none
// ============================================================================
// Module   : augmented_reader
// Purpose  : Streams a complete augmented image out of BRAM once the writer
//            signals it is present. Reads are issued one per cycle into a
//            2-entry output FIFO. Reads are throttled so that buffered plus
//            in-flight pixels never exceed two, so no returned pixel is lost.
//            When the last pixel has been accepted, the module pulses
//            image_read.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            image_written       - pulse: image ready in BRAM
//            bram_addr/bram_en   - BRAM read port (data one cycle later)
//            bram_rdata          - BRAM read data
//            pixel_out/_valid    - output stream, held stable while stalled
//            pixel_out_ready     - consumer accept
//            busy                - image being read (READ or DRAIN)
//            image_read          - pulse: last pixel accepted, BRAM free
//            pixel_out_last      - (only with AUGMENTED_READER_LAST_EN)
//                                  final pixel is at the output
// Macro    : AUGMENTED_READER_LAST_EN adds the pixel_out_last port
// Revision : 1.0 - initial release
// ============================================================================
module augmented_reader #(
    parameter int PIXEL_WIDTH = 8,
    parameter int NUM_PIXELS  = 784,
    parameter int ADDR_WIDTH  = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   image_written,
    output logic [ADDR_WIDTH-1:0]  bram_addr,
    output logic                   bram_en,
    input  logic [PIXEL_WIDTH-1:0] bram_rdata,
    output logic [PIXEL_WIDTH-1:0] pixel_out,
    output logic                   pixel_out_valid,
    input  logic                   pixel_out_ready,
    output logic                   busy,
    output logic                   image_read
`ifdef AUGMENTED_READER_LAST_EN
    ,
    output logic                   pixel_out_last
`endif
);

    localparam int c_PX_W = $clog2(NUM_PIXELS + 1);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);
    localparam logic [c_PX_W-1:0]     c_LAST_PX   = c_PX_W'(NUM_PIXELS - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_READ  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [ADDR_WIDTH-1:0]  r_rd_addr;
    logic [c_PX_W-1:0]      r_px_cnt;
    logic                   r_inflight;
    logic [PIXEL_WIDTH-1:0] r_fifo0;     // FIFO head
    logic [PIXEL_WIDTH-1:0] r_fifo1;
    logic [1:0]             r_fifo_cnt;
    logic                   r_image_read;

    logic                   w_pop;
    logic                   w_issue;
    logic [2:0]             w_level;
    logic                   w_last_pop;
    logic                   w_start;

    // Outputs are forced to zero during the reset cycle itself, not only
    // after the registers have cleared.
    assign pixel_out_valid = !reset && (r_fifo_cnt != 2'd0);
    assign pixel_out       = reset ? '0 : r_fifo0;
    assign bram_addr       = reset ? '0 : r_rd_addr;
    assign bram_en         = w_issue;
    assign busy            = !reset && (r_state != c_ST_IDLE);
    assign image_read      = !reset && r_image_read;

`ifdef AUGMENTED_READER_LAST_EN
    // r_px_cnt counts accepted pixels, so it is the index of the head pixel.
    assign pixel_out_last  = pixel_out_valid && (r_px_cnt == c_LAST_PX);
`endif

    assign w_pop   = pixel_out_valid && pixel_out_ready;
    assign w_start = (r_state == c_ST_IDLE) && image_written;

    // Occupancy after this cycle's pop: buffered + in flight - popped.
    // A new read is issued only when this occupancy leaves room for one more
    // pixel, so the 2-entry FIFO can never overflow.
    assign w_level    = {1'b0, r_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue    = !reset && (r_state == c_ST_READ) && (w_level < 3'd2);
    assign w_last_pop = w_pop && (r_state == c_ST_DRAIN) && (r_px_cnt == c_LAST_PX);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (image_written) w_state_nxt = c_ST_READ;
            c_ST_READ:  if (w_issue && (r_rd_addr == c_LAST_ADDR)) w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: if (w_last_pop) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_rd_addr    <= '0;
            r_px_cnt     <= '0;
            r_inflight   <= 1'b0;
            r_fifo0      <= '0;
            r_fifo1      <= '0;
            r_fifo_cnt   <= 2'd0;
            r_image_read <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_inflight   <= w_issue;
            r_image_read <= w_last_pop;

            if (w_start) begin
                r_rd_addr <= '0;
                r_px_cnt  <= '0;
            end else begin
                if (w_issue) r_rd_addr <= r_rd_addr + 1'b1;
                if (w_pop)   r_px_cnt  <= r_px_cnt + 1'b1;
            end

            // Shift-register FIFO: the head only changes on a pop, which
            // keeps pixel_out stable while the consumer stalls.
            case ({r_inflight, w_pop})
                2'b10: begin
                    if (r_fifo_cnt == 2'd0) r_fifo0 <= bram_rdata;
                    else                    r_fifo1 <= bram_rdata;
                    r_fifo_cnt <= r_fifo_cnt + 2'd1;
                end
                2'b01: begin
                    r_fifo0    <= r_fifo1;
                    r_fifo_cnt <= r_fifo_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_fifo_cnt == 2'd1) begin
                        r_fifo0 <= bram_rdata;
                    end else begin
                        r_fifo0 <= r_fifo1;
                        r_fifo1 <= bram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_augmented_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_augmented_reader
// Purpose  : Scoreboard bench for augmented_reader. Stimulus pushes the
//            expected pixel stream of each image into a queue. A negedge
//            monitor pops and compares each pixel on a handshake. It also
//            checks image_read timing, pixel stability during stalls, read
//            throttling and the reset values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_augmented_reader;

    localparam int NPIX = 784;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        image_written = 1'b0;
    logic [10:0] bram_addr;
    logic        bram_en;
    logic [7:0]  bram_rdata = 8'd0;
    logic [7:0]  pixel_out;
    logic        pixel_out_valid;
    logic        pixel_out_ready = 1'b1;
    logic        busy;
    logic        image_read;
`ifdef AUGMENTED_READER_LAST_EN
    logic        pixel_out_last;
`endif

    augmented_reader #(.PIXEL_WIDTH(8), .NUM_PIXELS(NPIX), .ADDR_WIDTH(11)) dut (
        .clk             (clk),
        .reset           (reset),
        .image_written   (image_written),
        .bram_addr       (bram_addr),
        .bram_en         (bram_en),
        .bram_rdata      (bram_rdata),
        .pixel_out       (pixel_out),
        .pixel_out_valid (pixel_out_valid),
        .pixel_out_ready (pixel_out_ready),
        .busy            (busy),
        .image_read      (image_read)
`ifdef AUGMENTED_READER_LAST_EN
        ,
        .pixel_out_last  (pixel_out_last)
`endif
    );

    always #5 clk = ~clk;

    // BRAM model preloaded with pixel[i] = i mod 256, one-cycle read latency.
    always @(posedge clk) if (bram_en) bram_rdata <= bram_addr[7:0];

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct packed {
        logic [7:0] pix;
        logic       last;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   hs_count = 0;

    task automatic check(input string name, input bit ok, input int act, input int req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    endtask

    task automatic push_image();
        exp_t e;
        for (int i = 0; i < NPIX; i++) begin
            e.pix  = 8'(i % 256);
            e.last = (i == NPIX - 1);
            q.push_back(e);
        end
    endtask

    // ---------------- monitor ----------------
    int   outstanding = 0;
    bit   exp_ir = 1'b0;
    bit   prev_stall = 1'b0;
    logic [7:0] prev_pix = 8'd0;

    always @(negedge clk) begin
        bit   hs;
        bit   last_seen;
        exp_t e;
        if (reset) begin
            check("reset_outputs_zero",
                  {bram_en, bram_addr, pixel_out_valid, pixel_out, busy, image_read} == '0,
                  int'({bram_en, pixel_out_valid, busy, image_read}), 0);
            outstanding = 0;
            exp_ir      = 1'b0;
            prev_stall  = 1'b0;
        end else begin
            hs        = pixel_out_valid && pixel_out_ready;
            last_seen = 1'b0;
            if (exp_ir || image_read)
                check("image_read_pulse", image_read == exp_ir, int'(image_read), int'(exp_ir));
            if (prev_stall)
                check("stall_stability", pixel_out_valid && (pixel_out == prev_pix),
                      int'(pixel_out), int'(prev_pix));
            if (bram_en)
                check("bram_en_throttle", (outstanding - int'(hs)) < 2,
                      outstanding - int'(hs), 1);
`ifdef AUGMENTED_READER_LAST_EN
            check("pixel_out_last",
                  pixel_out_last == (pixel_out_valid && q.size() > 0 && q[0].last),
                  int'(pixel_out_last), int'(pixel_out_valid && q.size() > 0 && q[0].last));
`endif
            if (hs) begin
                hs_count++;
                if (q.size() == 0) begin
                    check("unexpected_pixel", 1'b0, int'(pixel_out), -1);
                end else begin
                    e = q.pop_front();
                    check("pixel_value", pixel_out == e.pix, int'(pixel_out), int'(e.pix));
                    last_seen = e.last;
                end
            end
            outstanding = outstanding + int'(bram_en) - int'(hs);
            prev_stall  = pixel_out_valid && !pixel_out_ready;
            prev_pix    = pixel_out;
            exp_ir      = last_seen;
        end
    end

    // ---------------- stimulus helpers ----------------
    int t0;

    task automatic pulse(input bit expect_image);
        @(posedge clk); #1;
        image_written = 1'b1;
        if (expect_image) push_image();
        t0 = cyc_cnt;
        @(posedge clk); #1;
        image_written = 1'b0;
    endtask

    // mode 0: ready held 1; mode 1: ready toggles with random 10-cycle stalls.
    // Returns at posedge+1 of the image_read cycle.
    task automatic drive_until_read(input int mode, input int budget, output int t_done);
        int  stall = 0;
        bit  done = 1'b0;
        int  n = 0;
        t_done = -1;
        while (!done && n < budget) begin
            @(posedge clk); #1;
            if (image_read) begin
                done   = 1'b1;
                t_done = cyc_cnt;
            end else if (mode == 0) begin
                pixel_out_ready = 1'b1;
            end else if (stall > 0) begin
                pixel_out_ready = 1'b0;
                stall--;
            end else if ($urandom_range(0, 49) == 0) begin
                pixel_out_ready = 1'b0;
                stall = 9;
            end else begin
                pixel_out_ready = ~pixel_out_ready;
            end
            n++;
        end
        check("image_read_seen", done, int'(done), 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_done;
        int base;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // T1: latency and full-rate throughput
        pixel_out_ready = 1'b1;
        pulse(1'b1);
        @(negedge clk);                     // cycle 1
        check("lat_bram_en_c1", bram_en && bram_addr == 11'd0, int'(bram_addr), 0);
        check("lat_busy_c1", busy, int'(busy), 1);
        @(negedge clk);                     // cycle 2
        check("lat_invalid_c2", !pixel_out_valid, int'(pixel_out_valid), 0);
        @(negedge clk);                     // cycle 3
        check("lat_valid_c3", pixel_out_valid && pixel_out == 8'd0, int'(pixel_out_valid), 1);
        drive_until_read(0, 2000, t_done);
        check("throughput_cycles", t_done - t0 == NPIX + 3, t_done - t0, NPIX + 3);
        @(negedge clk);
        check("idle_after_read", !busy && !pixel_out_valid && !bram_en, int'(busy), 0);

        // T2: ready toggling with random stalls
        repeat (3) @(posedge clk);
        pulse(1'b1);
        drive_until_read(1, 6000, t_done);
        check("queue_empty_t2", q.size() == 0, q.size(), 0);

        // T3: pulse during READ ignored; pulse in image_read cycle accepted
        #0 pixel_out_ready = 1'b1;
        pulse(1'b1);
        repeat (50) @(posedge clk);
        pulse(1'b0);
        drive_until_read(0, 2000, t_done);
        check("queue_empty_t3", q.size() == 0, q.size(), 0);
        image_written = 1'b1;               // still in the image_read cycle
        push_image();
        @(posedge clk); #1;
        image_written = 1'b0;
        @(negedge clk);
        check("restart_bram_en", bram_en && bram_addr == 11'd0, int'(bram_en), 1);
        drive_until_read(0, 2000, t_done);
        repeat (10) @(posedge clk);
        check("queue_empty_t3b", q.size() == 0, q.size(), 0);

        // T4: reset after pixel 100 accepted, then restart from pixel 0
        base = hs_count;
        pulse(1'b1);
        for (int i = 0; i < 400 && hs_count < base + 101; i++) begin
            @(posedge clk); #1;
        end
        check("reached_pixel_100", hs_count >= base + 101, hs_count - base, 101);
        reset = 1'b1;
        q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_idle", !busy && !pixel_out_valid && !bram_en && !image_read,
              int'({busy, pixel_out_valid, bram_en, image_read}), 0);
        repeat (3) @(posedge clk);
        pulse(1'b1);
        drive_until_read(0, 2000, t_done);
        repeat (5) @(posedge clk);
        check("queue_empty_final", q.size() == 0, q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/augmented_reader.md
AUGMENTED_READER -- requirements
Module: augmented_reader

Interface
REQ-001 Parameter PIXEL_WIDTH, default 8: bits per pixel.
REQ-002 Parameter NUM_PIXELS, default 784: pixels per image.
REQ-003 Parameter ADDR_WIDTH, default 11: BRAM address width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  reset is synchronous and active-high.
REQ-006 image_written  input  1  one-cycle pulse: complete augmented image is present in BRAM.
REQ-007 bram_addr  output  ADDR_WIDTH  BRAM read address.
REQ-008 bram_en  output  1  BRAM read enable.
REQ-009 bram_rdata  input  PIXEL_WIDTH  BRAM read data, valid one cycle after bram_en.
REQ-010 pixel_out  output  PIXEL_WIDTH  streamed pixel.
REQ-011 pixel_out_valid  output  1  pixel_out holds a valid pixel.
REQ-012 pixel_out_ready  input  1  consumer accepts pixel; handshake = valid & ready.
REQ-013 busy  output  1  an image is being read.
REQ-014 image_read  output  1  one-cycle pulse: final pixel accepted, BRAM free for next write.

Function
REQ-015 The FSM SHALL have states IDLE, READ and DRAIN.
REQ-016 IDLE->READ on image_written=1; the read address counter and pixel counter SHALL clear to 0.
REQ-017 In READ, bram_en SHALL be 1 and bram_addr SHALL equal the read counter whenever buffered+in-flight pixels minus this cycle's pop is less than 2.
REQ-018 Each issued read SHALL increment the read counter; after address NUM_PIXELS-1 is issued, READ->DRAIN.
REQ-019 Returned data SHALL enter a 2-entry output FIFO the cycle after bram_en; no returned pixel SHALL ever be dropped.
REQ-020 pixel_out_valid SHALL be 1 whenever the FIFO is non-empty; pixel_out SHALL be the FIFO head.
REQ-021 While pixel_out_valid=1 and pixel_out_ready=0, pixel_out SHALL remain stable.
REQ-022 Pixels SHALL emerge in address order 0..NUM_PIXELS-1, exactly NUM_PIXELS per image.
REQ-023 Latency: image_written in cycle 0 -> bram_en/addr 0 in cycle 1 -> pixel_out_valid in cycle 3.
REQ-024 Throughput: with pixel_out_ready held 1, one pixel per cycle; the full image completes in NUM_PIXELS+2 cycles from the first bram_en.
REQ-025 With pixel_out_ready held 0, bram_en SHALL drop once 2 pixels are buffered or in flight.
REQ-026 In DRAIN, the handshake of pixel NUM_PIXELS-1 SHALL cause image_read=1 in the next cycle with the state returning to IDLE in that same cycle.
REQ-027 image_written arriving in the image_read cycle SHALL be accepted; image_written in READ or DRAIN SHALL be ignored.
REQ-028 busy SHALL be 1 in READ and DRAIN, 0 in IDLE.
REQ-029 bram_en SHALL be 0 in IDLE and DRAIN.

Reset
REQ-030 With reset=1 at a clock edge: state IDLE, counters 0, FIFO empty.
REQ-031 While in reset: bram_en=0, bram_addr=0, pixel_out_valid=0, pixel_out=0, busy=0, image_read=0.
REQ-032 Reset mid-image SHALL abort it; returning BRAM data SHALL be discarded; image_read SHALL not pulse.

Configuration
REQ-033 Macro AUGMENTED_READER_LAST_EN defined: output pixel_out_last (1 bit) SHALL be 1 exactly while pixel NUM_PIXELS-1 is at the FIFO head with pixel_out_valid=1, and 0 under reset.
REQ-034 Macro not defined: port pixel_out_last SHALL be absent; all other behaviour is identical.

Verification
REQ-035 BRAM preloaded with pixel[i]=i mod 256, ready=1, image_written pulse -> 784 pixels 0,1,..,255,0,.. on consecutive cycles; first valid 3 cycles after pulse; image_read 1 cycle after the 784th handshake.
REQ-036 ready toggling 1/0 every cycle plus random 10-cycle stalls -> same ordered 784 pixels, no duplicates or drops, pixel_out stable during stalls, bram_en=0 when 2 pixels are buffered.
REQ-037 Reset asserted after pixel 100 accepted -> all outputs 0 next cycle, no image_read; a new pulse restarts from pixel 0.
REQ-038 Second image_written during READ -> ignored, exactly 784 pixels; pulse in the image_read cycle -> second image starts, bram_en in the following cycle.
REQ-039 With AUGMENTED_READER_LAST_EN -> pixel_out_last=1 only with pixel 783, held during a stall on that pixel; build without the macro compiles with no pixel_out_last port.
